mole_scheduler: RTL

Decides when and where a new mole pops up during a round of Whack-A-Mole. Drives the `mole`/`moletime` inputs of a bank of per-hole mole timers and reads back their `omole` outputs to track which holes are occupied. Spawn gaps and the number of moles allowed up at once scale with difficulty. Hole selection is pseudo-random with linear probing over occupied holes.

---
 rtl/mole_scheduler_if.sv | 11 +
 rtl/mole_scheduler.sv | 113 +++++++++++
 2 files changed

// File: rtl/mole_scheduler_if.sv
// rtl/mole_scheduler_if.sv - scheduler to mole-timer bank signals
interface mole_scheduler_if #(
  parameter int NUM_HOLES = 9
);
  logic [NUM_HOLES-1:0] spawn;
  logic [2:0]           moletime;
  logic [NUM_HOLES-1:0] mole_up;

  modport master (output spawn, output moletime, input mole_up);
  modport slave  (input spawn, input moletime, output mole_up);
endinterface

// File: rtl/mole_scheduler.sv
// rtl/mole_scheduler.sv - picks when and where the next mole pops up
module mole_scheduler #(
  parameter int NUM_HOLES = 9,
  parameter int TICK      = 10_000_000
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic [1:0]        difficulty,
  input  logic              game_active,
  mole_scheduler_if.master  bank,
  output logic [7:0]        spawn_count
);

  localparam int          GAP_MAX = 27 * TICK;
  localparam int          CW      = $clog2(GAP_MAX + 1);
  localparam logic [4:0]  NH      = 5'(NUM_HOLES);
  localparam logic [3:0]  LAST    = 4'(NUM_HOLES - 1);

  typedef enum logic [1:0] {IDLE, GAP, PICK, FIRE} state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic [CW-1:0] gap_cnt;
  logic [3:0]    cand;
  logic [3:0]    probes;

  logic [15:0]   lfsr_next;
  logic [4:0]    base;
  logic [CW-1:0] gap_load;
  logic [1:0]    limit;
  logic [4:0]    occ;
  logic          limit_ok;
  logic [4:0]    raw;
  logic [3:0]    cand0;
  logic [3:0]    cand_next;

  always_comb begin
    lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

    case (difficulty)
      2'b00:   begin base = 5'd20; limit = 2'd1; end
      2'b01:   begin base = 5'd12; limit = 2'd2; end
      default: begin base = 5'd6;  limit = 2'd3; end
    endcase

    // Counter holds G-1 so that PICK is entered exactly G cycles after GAP entry
    gap_load = CW'(base + {2'b00, lfsr[6:4]}) * CW'(TICK) - CW'(1);

    occ      = 5'($countones(bank.mole_up));
    limit_ok = occ < {3'b000, limit};

    raw       = {1'b0, lfsr[3:0]};
    cand0     = (raw >= NH) ? 4'(raw - NH) : lfsr[3:0];
    cand_next = ({1'b0, cand} == NH - 5'd1) ? 4'd0 : cand + 4'd1;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state         <= IDLE;
      lfsr          <= 16'hACE1;
      gap_cnt       <= '0;
      cand          <= '0;
      probes        <= '0;
      bank.spawn    <= '0;
      bank.moletime <= '0;
      spawn_count   <= '0;
    end else begin
      lfsr       <= lfsr_next;
      bank.spawn <= '0;
      if (!game_active) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            spawn_count <= '0;
            gap_cnt     <= gap_load;
            state       <= GAP;
          end
          GAP: begin
            if (gap_cnt != '0) begin
              gap_cnt <= gap_cnt - CW'(1);
            end else if (limit_ok) begin
              // Hole and duration are drawn from the LFSR as PICK is entered
              cand          <= cand0;
              probes        <= '0;
              bank.moletime <= lfsr[9:7];
              state         <= PICK;
            end
          end
          PICK: begin
            if (!bank.mole_up[cand]) begin
              bank.spawn[cand] <= 1'b1;
              if (spawn_count != 8'hFF) spawn_count <= spawn_count + 8'd1;
              state <= FIRE;
            end else if (probes == LAST) begin
              gap_cnt <= gap_load;
              state   <= GAP;
            end else begin
              cand   <= cand_next;
              probes <= probes + 4'd1;
            end
          end
          FIRE: begin
            gap_cnt <= gap_load;
            state   <= GAP;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
